branch_predict_unit: RTL and testbench

- Parametrised successor to the single-cycle branch resolver. Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters (BHT), which gives fetch-stage prediction.
- Resolves branches, jumps, JALR and halt in the execute stage and detects mispredictions. Drives the PC redirect.
- Holds a sticky halt state until reset.
- Sits between the fetch PC mux (prediction port) and the execute stage (resolve port).

---
 rtl/bp_pkg.sv | 35 +++
 rtl/branch_pred_table.sv | 66 ++++++
 rtl/branch_predict_unit.sv | 143 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for branch_predict_unit: counter encoding, BTB entry layout and the
// saturating counter update. Entry field widths are set by BP_PC_W / BP_IDX_W here.
package bp_pkg;

    localparam int BP_PC_W  = 9;
    localparam int BP_IDX_W = 4;
    localparam int BP_TAG_W = BP_PC_W - BP_IDX_W - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
        logic                is_jump;
        ctr_t                ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        if (taken && ctr != ST) begin
            nxt = ctr_t'(ctr + 2'd1);
        end else if (!taken && ctr != SNT) begin
            nxt = ctr_t'(ctr - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_pred_table.sv
// Direct-mapped BTB/BHT storage: combinational fetch read, synchronous resolve write
// with an internal read-modify-write of the addressed entry's counter.
module branch_pred_table
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_W-1:0]    rd_idx_i,
    output btb_entry_t          rd_entry_o,
    input  logic                wr_en_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic [BP_TAG_W-1:0] wr_tag_i,
    input  logic [BP_PC_W-1:0]  wr_target_i,
    input  logic                wr_jump_i,
    input  logic                wr_taken_i
);

    localparam int DEPTH = 1 << IDX_W;

    btb_entry_t mem_q [DEPTH];
    btb_entry_t cur_entry;
    btb_entry_t wr_entry_d;
    logic       wr_hit;
    logic       wr_do;

    assign rd_entry_o = mem_q[rd_idx_i];
    assign cur_entry  = mem_q[wr_idx_i];
    assign wr_hit     = cur_entry.valid && (cur_entry.tag == wr_tag_i);

    always_comb begin
        // NOTE: defaults assigned first so every path drives every signal (no latch).
        wr_do      = 1'b0;
        wr_entry_d = cur_entry;
        if (wr_en_i) begin
            if (wr_jump_i) begin
                wr_do      = 1'b1;
                wr_entry_d = '{valid: 1'b1, tag: wr_tag_i, target: wr_target_i,
                               is_jump: 1'b1, ctr: ST};
            end else if (wr_taken_i) begin
                // A miss or tag mismatch reallocates the slot starting at weakly-taken.
                wr_do      = 1'b1;
                wr_entry_d = '{valid: 1'b1, tag: wr_tag_i, target: wr_target_i,
                               is_jump: 1'b0,
                               ctr: wr_hit ? ctr_next(cur_entry.ctr, 1'b1) : WT};
            end else if (wr_hit) begin
                wr_do          = 1'b1;
                wr_entry_d.ctr = ctr_next(cur_entry.ctr, 1'b0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the table is built from flops, so clearing every entry is legal; valid and ctr must start known.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, is_jump: 1'b0, ctr: WNT};
            end
        end else if (wr_do) begin
            // NOTE: non-blocking, so a fetch read in this cycle still sees the pre-write entry.
            mem_q[wr_idx_i] <= wr_entry_d;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage BTB prediction plus execute-stage branch/jump/halt resolution and redirect.
// Optional BP_STATS_EN adds branch and misprediction counters.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int PC_W  = BP_PC_W,
    parameter int IDX_W = BP_IDX_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] F_PC,
    output logic            Pred_Taken,
    output logic [PC_W-1:0] Pred_Target,
    input  logic            Ex_Valid,
    input  logic [PC_W-1:0] Ex_PC,
    input  logic [31:0]     Ex_Imm,
    input  logic            Ex_Branch,
    input  logic            Ex_Jump,
    input  logic            Ex_JumpR,
    input  logic            Ex_Halt,
    input  logic [31:0]     Ex_AluResult,
    input  logic            Ex_PredTaken,
    input  logic [PC_W-1:0] Ex_PredTarget,
    output logic [31:0]     PC_Four,
    output logic [31:0]     PC_Imm,
    output logic            Redirect,
    output logic [31:0]     Redirect_PC,
    output logic            Halted
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     Br_Count,
    output logic [31:0]     Mispred_Count
`endif
);

    localparam int TAG_W = PC_W - IDX_W - 2;

    btb_entry_t      f_entry;
    logic [TAG_W-1:0] f_tag;
    logic [TAG_W-1:0] ex_tag;
    logic            f_hit;
    logic            resolve_en;
    logic            taken;
    logic            mispred;
    logic            wr_en;
    logic [31:0]     pc_four;
    logic [31:0]     pc_imm;
    logic [31:0]     tgt;
    logic            halted_q;
    logic            halted_d;
    logic [PC_W-1:0] halted_pc_q;
    logic [PC_W-1:0] halted_pc_d;
    logic            unused_bits;

    assign unused_bits = ^{F_PC[1:0], f_entry.ctr[0]};
    assign f_tag       = F_PC[PC_W-1:IDX_W+2];
    assign ex_tag      = Ex_PC[PC_W-1:IDX_W+2];

    branch_pred_table #(.IDX_W(IDX_W)) u_table (
        .clk         (clk),
        .reset       (reset),
        .rd_idx_i    (F_PC[IDX_W+1:2]),
        .rd_entry_o  (f_entry),
        .wr_en_i     (wr_en),
        .wr_idx_i    (Ex_PC[IDX_W+1:2]),
        .wr_tag_i    (ex_tag),
        .wr_target_i (tgt[PC_W-1:0]),
        .wr_jump_i   (Ex_Jump),
        .wr_taken_i  (Ex_AluResult[0])
    );

    assign f_hit       = f_entry.valid && (f_entry.tag == f_tag);
    assign Pred_Taken  = !reset && f_hit && (f_entry.is_jump || f_entry.ctr[1]);
    assign Pred_Target = (!reset && f_hit) ? f_entry.target : '0;

    assign resolve_en = Ex_Valid && !halted_q && !reset;
    assign pc_four    = 32'(Ex_PC) + 32'd4;
    assign pc_imm     = 32'(Ex_PC) + Ex_Imm;
    assign taken      = (Ex_Branch && Ex_AluResult[0]) || Ex_Jump || Ex_JumpR;
    assign tgt        = Ex_JumpR ? {Ex_AluResult[31:1], 1'b0} : pc_imm;
    assign mispred    = (taken != Ex_PredTaken) || (taken && (Ex_PredTarget != tgt[PC_W-1:0]));
    // JALR targets are data-dependent, so they never train the table.
    assign wr_en      = resolve_en && !Ex_Halt && (Ex_Jump || (Ex_Branch && !Ex_JumpR));

    assign PC_Four = resolve_en ? pc_four : '0;
    assign PC_Imm  = resolve_en ? pc_imm : '0;
    assign Halted  = halted_q && !reset;

    always_comb begin
        Redirect    = 1'b0;
        Redirect_PC = '0;
        halted_d    = halted_q;
        halted_pc_d = halted_pc_q;
        if (!reset) begin
            if (halted_q) begin
                Redirect    = 1'b1;
                Redirect_PC = 32'(halted_pc_q);
            end else if (resolve_en && Ex_Halt) begin
                Redirect    = 1'b1;
                Redirect_PC = 32'(Ex_PC);
                halted_d    = 1'b1;
                halted_pc_d = Ex_PC;
            end else if (resolve_en && mispred) begin
                Redirect    = 1'b1;
                Redirect_PC = taken ? tgt : pc_four;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q    <= 1'b0;
            halted_pc_q <= '0;
        end else begin
            halted_q    <= halted_d;
            halted_pc_q <= halted_pc_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] br_cnt_d;
    logic [31:0] mis_cnt_q;
    logic [31:0] mis_cnt_d;

    assign br_cnt_d  = br_cnt_q + 32'(resolve_en && !Ex_Halt && (Ex_Branch || Ex_Jump || Ex_JumpR));
    assign mis_cnt_d = mis_cnt_q + 32'(resolve_en && !Ex_Halt && mispred);

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign Br_Count      = reset ? '0 : br_cnt_q;
    assign Mispred_Count = reset ? '0 : mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed steps plus random resolves
// checked against an array-based predictor model.
`timescale 1ns/1ps
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  F_PC;
    logic        Pred_Taken;
    logic [8:0]  Pred_Target;
    logic        Ex_Valid;
    logic [8:0]  Ex_PC;
    logic [31:0] Ex_Imm;
    logic        Ex_Branch;
    logic        Ex_Jump;
    logic        Ex_JumpR;
    logic        Ex_Halt;
    logic [31:0] Ex_AluResult;
    logic        Ex_PredTaken;
    logic [8:0]  Ex_PredTarget;
    logic [31:0] PC_Four;
    logic [31:0] PC_Imm;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        Halted;
`ifdef BP_STATS_EN
    logic [31:0] Br_Count;
    logic [31:0] Mispred_Count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_valid  [16];
    bit [2:0]    m_tag    [16];
    bit [8:0]    m_target [16];
    bit          m_jump   [16];
    int          m_ctr    [16];
    bit          m_halted;
    bit [8:0]    m_hpc;
    int unsigned m_br;
    int unsigned m_mis;

    always #5 clk = ~clk;

    branch_predict_unit #(.PC_W(9), .IDX_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .F_PC          (F_PC),
        .Pred_Taken    (Pred_Taken),
        .Pred_Target   (Pred_Target),
        .Ex_Valid      (Ex_Valid),
        .Ex_PC         (Ex_PC),
        .Ex_Imm        (Ex_Imm),
        .Ex_Branch     (Ex_Branch),
        .Ex_Jump       (Ex_Jump),
        .Ex_JumpR      (Ex_JumpR),
        .Ex_Halt       (Ex_Halt),
        .Ex_AluResult  (Ex_AluResult),
        .Ex_PredTaken  (Ex_PredTaken),
        .Ex_PredTarget (Ex_PredTarget),
        .PC_Four       (PC_Four),
        .PC_Imm        (PC_Imm),
        .Redirect      (Redirect),
        .Redirect_PC   (Redirect_PC),
        .Halted        (Halted)
`ifdef BP_STATS_EN
        ,
        .Br_Count      (Br_Count),
        .Mispred_Count (Mispred_Count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_jump[i]   = 1'b0;
            m_ctr[i]    = 1;
        end
        m_halted = 1'b0;
        m_hpc    = '0;
        m_br     = 0;
        m_mis    = 0;
    endtask

    task automatic model_pred(input logic [8:0] pc, output logic tk, output logic [8:0] tg);
        int   i;
        logic hit;
        i   = int'(pc[5:2]);
        hit = m_valid[i] && (m_tag[i] == pc[8:6]);
        tk  = hit && (m_jump[i] || m_ctr[i] >= 2);
        tg  = hit ? m_target[i] : 9'd0;
    endtask

    task automatic model_resolve(output logic tk, output logic [31:0] tgt, output logic mis,
                                 output logic [31:0] pc4, output logic [31:0] pcimm);
        pc4   = {23'd0, Ex_PC} + 32'd4;
        pcimm = {23'd0, Ex_PC} + Ex_Imm;
        tk    = (Ex_Branch && Ex_AluResult[0]) || Ex_Jump || Ex_JumpR;
        tgt   = Ex_JumpR ? (Ex_AluResult & 32'hFFFF_FFFE) : pcimm;
        mis   = (tk != Ex_PredTaken) || (tk && (Ex_PredTarget != tgt[8:0]));
    endtask

    task automatic check_all(input string tag);
        logic        ptk, tk, mis, act, rd;
        logic [8:0]  ptg;
        logic [31:0] tgt, pc4, pcimm, rpc;
        model_pred(F_PC, ptk, ptg);
        model_resolve(tk, tgt, mis, pc4, pcimm);
        act = Ex_Valid && !m_halted;
        rd  = 1'b0;
        rpc = '0;
        if (m_halted) begin
            rd  = 1'b1;
            rpc = {23'd0, m_hpc};
        end else if (act && Ex_Halt) begin
            rd  = 1'b1;
            rpc = {23'd0, Ex_PC};
        end else if (act && mis) begin
            rd  = 1'b1;
            rpc = tk ? tgt : pc4;
        end
        check({tag, ".pred_taken"}, 32'(Pred_Taken), 32'(ptk));
        check({tag, ".pred_target"}, 32'(Pred_Target), 32'(ptg));
        check({tag, ".redirect"}, 32'(Redirect), 32'(rd));
        check({tag, ".redirect_pc"}, Redirect_PC, rpc);
        check({tag, ".pc_four"}, PC_Four, act ? pc4 : 32'd0);
        check({tag, ".pc_imm"}, PC_Imm, act ? pcimm : 32'd0);
        check({tag, ".halted"}, 32'(Halted), 32'(m_halted));
`ifdef BP_STATS_EN
        check({tag, ".br_count"}, Br_Count, m_br);
        check({tag, ".mispred_count"}, Mispred_Count, m_mis);
`endif
    endtask

    // Applies the state change the DUT makes at the coming clock edge.
    task automatic model_commit();
        logic        tk, mis, hit;
        logic [31:0] tgt, pc4, pcimm;
        int          i;
        model_resolve(tk, tgt, mis, pc4, pcimm);
        i   = int'(Ex_PC[5:2]);
        hit = m_valid[i] && (m_tag[i] == Ex_PC[8:6]);
        if (Ex_Valid && !m_halted) begin
            if (Ex_Halt) begin
                m_halted = 1'b1;
                m_hpc    = Ex_PC;
            end else begin
                if (Ex_Branch || Ex_Jump || Ex_JumpR) m_br++;
                if (mis) m_mis++;
                if (Ex_Jump) begin
                    m_valid[i] = 1'b1; m_tag[i] = Ex_PC[8:6]; m_target[i] = tgt[8:0];
                    m_jump[i]  = 1'b1; m_ctr[i] = 3;
                end else if (Ex_JumpR) begin
                    // no training
                end else if (Ex_Branch && Ex_AluResult[0]) begin
                    m_ctr[i]    = hit ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : 2;
                    m_valid[i]  = 1'b1; m_tag[i] = Ex_PC[8:6]; m_target[i] = tgt[8:0];
                    m_jump[i]   = 1'b0;
                end else if (Ex_Branch && hit) begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [8:0] pc,
                        input logic [31:0] imm, input logic [3:0] ctl, input logic [31:0] alu,
                        input logic pt, input logic [8:0] ptg, input logic [8:0] fpc);
        @(negedge clk);
        Ex_Valid      = v;
        Ex_PC         = pc;
        Ex_Imm        = imm;
        {Ex_Branch, Ex_Jump, Ex_JumpR, Ex_Halt} = ctl;
        Ex_AluResult  = alu;
        Ex_PredTaken  = pt;
        Ex_PredTarget = ptg;
        F_PC          = fpc;
        #1;
        check_all(tag);
        model_commit();
    endtask

    task automatic reset_dut(input string tag);
        @(negedge clk);
        reset = 1'b1;
        Ex_Valid = 1'b0; Ex_PC = '0; Ex_Imm = '0;
        {Ex_Branch, Ex_Jump, Ex_JumpR, Ex_Halt} = 4'b0000;
        Ex_AluResult = '0; Ex_PredTaken = 1'b0; Ex_PredTarget = '0; F_PC = '0;
        #1;
        check({tag, ".redirect"}, 32'(Redirect), 32'd0);
        check({tag, ".halted"}, 32'(Halted), 32'd0);
        check({tag, ".pred_taken"}, 32'(Pred_Taken), 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [8:0] rand_pc();
        return {3'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    initial begin
        logic [8:0]  rpc;
        logic [8:0]  mptg;
        logic        mpt;
        logic [3:0]  ctl;
        logic [7:0]  r8;
        logic [31:0] imm;
        int          k;

        reset_dut("rst");

        step("idle", 1'b0, 9'h000, 32'h0, 4'b0000, 32'h0, 1'b0, 9'h0, 9'h010);
        check("idle.pred_taken_c", 32'(Pred_Taken), 32'd0);
        check("idle.redirect_c", 32'(Redirect), 32'd0);
        check("idle.halted_c", 32'(Halted), 32'd0);

        step("br_taken", 1'b1, 9'h020, 32'h40, 4'b1000, 32'h1, 1'b0, 9'h0, 9'h020);
        check("br_taken.redirect_c", 32'(Redirect), 32'd1);
        check("br_taken.redirect_pc_c", Redirect_PC, 32'h060);
        check("br_taken.no_bypass", 32'(Pred_Taken), 32'd0);

        step("pred_hit", 1'b0, 9'h000, 32'h0, 4'b0000, 32'h0, 1'b0, 9'h0, 9'h020);
        check("pred_hit.taken_c", 32'(Pred_Taken), 32'd1);
        check("pred_hit.target_c", 32'(Pred_Target), 32'h060);

        step("pred_alias", 1'b0, 9'h000, 32'h0, 4'b0000, 32'h0, 1'b0, 9'h0, 9'h120);
        check("pred_alias.taken_c", 32'(Pred_Taken), 32'd0);

        step("br_nt1", 1'b1, 9'h020, 32'h40, 4'b1000, 32'h0, 1'b1, 9'h060, 9'h020);
        check("br_nt1.pred_c", 32'(Pred_Taken), 32'd1);
        check("br_nt1.redirect_pc_c", Redirect_PC, 32'h024);
        step("br_nt2", 1'b1, 9'h020, 32'h40, 4'b1000, 32'h0, 1'b0, 9'h0, 9'h020);
        check("br_nt2.pred_c", 32'(Pred_Taken), 32'd0);
        check("br_nt2.redirect_c", 32'(Redirect), 32'd0);
        step("br_nt3", 1'b1, 9'h020, 32'h40, 4'b1000, 32'h0, 1'b0, 9'h0, 9'h020);
        check("br_nt3.redirect_c", 32'(Redirect), 32'd0);
        step("nt_pred", 1'b0, 9'h000, 32'h0, 4'b0000, 32'h0, 1'b0, 9'h0, 9'h020);
        check("nt_pred.taken_c", 32'(Pred_Taken), 32'd0);
        // One taken resolve from SNT must still leave the branch predicted not taken.
        step("br_sat", 1'b1, 9'h020, 32'h40, 4'b1000, 32'h1, 1'b0, 9'h0, 9'h020);
        check("br_sat.redirect_pc_c", Redirect_PC, 32'h060);
        step("sat_pred", 1'b0, 9'h000, 32'h0, 4'b0000, 32'h0, 1'b0, 9'h0, 9'h020);
        check("sat_pred.taken_c", 32'(Pred_Taken), 32'd0);

        step("jal", 1'b1, 9'h040, 32'hFFFF_FFF8, 4'b0100, 32'h0, 1'b0, 9'h0, 9'h040);
        check("jal.redirect_pc_c", Redirect_PC, 32'h038);
        step("jal_hit", 1'b1, 9'h040, 32'hFFFF_FFF8, 4'b0100, 32'h0, 1'b1, 9'h038, 9'h040);
        check("jal_hit.redirect_c", 32'(Redirect), 32'd0);
        check("jal_hit.pred_target_c", 32'(Pred_Target), 32'h038);

        step("jalr", 1'b1, 9'h040, 32'h0, 4'b0010, 32'h0000_0085, 1'b0, 9'h0, 9'h040);
        check("jalr.redirect_pc_c", Redirect_PC, 32'h084);
        step("jalr_tbl", 1'b0, 9'h000, 32'h0, 4'b0000, 32'h0, 1'b0, 9'h0, 9'h040);
        check("jalr_tbl.taken_c", 32'(Pred_Taken), 32'd1);
        check("jalr_tbl.target_c", 32'(Pred_Target), 32'h038);

        for (int n = 0; n < 400; n++) begin
            rpc = rand_pc();
            k   = int'($urandom_range(0, 9));
            ctl = (k < 5) ? 4'b1000 : (k < 7) ? 4'b0100 : (k < 8) ? 4'b0010 :
                  (k < 9) ? 4'b1100 : 4'b0000;
            model_pred(rpc, mpt, mptg);
            if ($urandom_range(0, 3) == 0) begin
                mpt  = 1'($urandom);
                mptg = 9'($urandom);
            end
            r8  = 8'($urandom);
            imm = ($urandom_range(0, 3) != 0) ? {{22{r8[7]}}, r8, 2'b00} : $urandom;
            step("rand", ($urandom_range(0, 4) != 0), rpc, imm, ctl, $urandom, mpt, mptg, rand_pc());
        end

        step("halt", 1'b1, 9'h0A0, 32'h0, 4'b0001, 32'h0, 1'b0, 9'h0, rand_pc());
        check("halt.redirect_c", 32'(Redirect), 32'd1);
        check("halt.redirect_pc_c", Redirect_PC, 32'h0A0);
        for (int n = 0; n < 20; n++) begin
            step("halted", 1'($urandom), rand_pc(), $urandom, 4'($urandom), $urandom,
                 1'($urandom), 9'($urandom), rand_pc());
            check("halted.halted_c", 32'(Halted), 32'd1);
            check("halted.redirect_pc_c", Redirect_PC, 32'h0A0);
        end

        reset_dut("rst2");
        step("post_rst", 1'b0, 9'h000, 32'h0, 4'b0000, 32'h0, 1'b0, 9'h0, 9'h040);
        check("post_rst.halted_c", 32'(Halted), 32'd0);
        check("post_rst.redirect_c", 32'(Redirect), 32'd0);
        check("post_rst.pred_taken_c", 32'(Pred_Taken), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
